mem_wb_stage: RTL and testbench

//  EX/MEM and MEM/WB pipeline registers plus data-memory access for the 4-bit-opcode, 16-register, 32-bit pipeline.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_reg_slot.sv | 45 ++++
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 tb/tb_mem_wb_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, MEM-stage FSM state type and the
// register-write predicate used by the MEM/WB stage, forwarding unit and decode.
package pipe_pkg;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [3:0] OP_SW     = 4'b0011;
    localparam logic [3:0] OP_LW     = 4'b0100;
    localparam logic [3:0] OP_ADD    = 4'b1100;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    function automatic logic writes_reg(input logic [3:0] opcode);
        return !((opcode == OP_NOP) || (opcode == OP_BRANCH) || (opcode == OP_SW));
    endfunction

endpackage

// File: rtl/pipe_reg_slot.sv
// One pipeline slot (opcode/index/data) with load enable and NOP bubble insertion.
// Bubble has priority over load; with neither asserted the slot holds.
module pipe_reg_slot
    import pipe_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [3:0]        opcode_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [3:0]        opcode_o,
    output logic [IDX_W-1:0]  index_o,
    output logic [DATA_W-1:0] data_o
);

    logic [3:0]        opcode_q;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= OP_NOP;
            index_q  <= '0;
            data_q   <= '0;
        end else if (bubble_i) begin
            opcode_q <= OP_NOP;
            index_q  <= '0;
            data_q   <= '0;
        end else if (load_i) begin
            opcode_q <= opcode_i;
            index_q  <= index_i;
            data_q   <= data_i;
        end
    end

    assign opcode_o = opcode_q;
    assign index_o  = index_q;
    assign data_o   = data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers with a ready-handshaked data-memory port.
// Optional build macro STALL_COUNT_EN adds a saturating stall_cycles counter output.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int bitwidth            = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ex_valid,
    input  logic [3:0]                     ex_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_index,
    input  logic [bitwidth-1:0]            ex_data,
    input  logic [bitwidth-1:0]            ex_store_data,
    input  logic                           flush,
    output logic                           stall_o,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [bitwidth-1:0]            mem_addr,
    output logic [bitwidth-1:0]            mem_wdata,
    input  logic                           mem_ready,
    input  logic [bitwidth-1:0]            mem_rdata,
    output logic [3:0]                     MEM_opcode,
    output logic [REG_INDEX_BIT_WIDTH-1:0] MEM_index,
    output logic [bitwidth-1:0]            MEM_data,
    output logic [3:0]                     WB_opcode,
    output logic [REG_INDEX_BIT_WIDTH-1:0] WB_index,
    output logic [bitwidth-1:0]            WB_data,
    output logic                           rf_we,
    output logic [REG_INDEX_BIT_WIDTH-1:0] rf_windex,
    output logic [bitwidth-1:0]            rf_wdata
`ifdef STALL_COUNT_EN
   ,output logic [15:0]                    stall_cycles
`endif
);

    logic               mem_op;
    logic               mem_load;
    logic               mem_bubble;
    logic [bitwidth-1:0] wb_data_in;
    logic [bitwidth-1:0] mem_st_q;
    mem_state_e         state_q, state_d;

    assign mem_op  = (MEM_opcode == OP_LW) || (MEM_opcode == OP_SW);
    assign stall_o = mem_op && !mem_ready;

    assign mem_req   = mem_op;
    assign mem_we    = (MEM_opcode == OP_SW);
    assign mem_addr  = MEM_data;
    assign mem_wdata = mem_st_q;

    // Flush only matters when the slot actually advances.
    assign mem_load   = !stall_o;
    assign mem_bubble = !stall_o && (!ex_valid || flush);

    pipe_reg_slot #(.IDX_W(REG_INDEX_BIT_WIDTH), .DATA_W(bitwidth)) u_mem_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (mem_load),
        .bubble_i (mem_bubble),
        .opcode_i (ex_opcode),
        .index_i  (ex_index),
        .data_i   (ex_data),
        .opcode_o (MEM_opcode),
        .index_o  (MEM_index),
        .data_o   (MEM_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_st_q <= '0;
        end else if (!stall_o) begin
            mem_st_q <= ex_store_data;
        end
    end

    assign wb_data_in = (MEM_opcode == OP_LW) ? mem_rdata : MEM_data;

    // While stalled, WB receives a bubble so neither RF nor forwarding sees a repeat.
    pipe_reg_slot #(.IDX_W(REG_INDEX_BIT_WIDTH), .DATA_W(bitwidth)) u_wb_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (1'b1),
        .bubble_i (stall_o),
        .opcode_i (MEM_opcode),
        .index_i  (MEM_index),
        .data_i   (wb_data_in),
        .opcode_o (WB_opcode),
        .index_o  (WB_index),
        .data_o   (WB_data)
    );

    assign rf_we     = writes_reg(WB_opcode);
    assign rf_windex = WB_index;
    assign rf_wdata  = WB_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mem_op && !mem_ready) state_d = WAIT;
            WAIT:    if (mem_ready)            state_d = RUN;
            default: state_d = RUN;
        endcase
    end

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, stalled loads, stores, flush,
// reset during a wait and back-to-back loads. Build with STALL_COUNT_EN to check the counter.
module tb_mem_wb_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_index;
    logic [31:0] ex_data;
    logic [31:0] ex_store_data;
    logic        flush;
    logic        stall_o;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  MEM_opcode;
    logic [3:0]  MEM_index;
    logic [31:0] MEM_data;
    logic [3:0]  WB_opcode;
    logic [3:0]  WB_index;
    logic [31:0] WB_data;
    logic        rf_we;
    logic [3:0]  rf_windex;
    logic [31:0] rf_wdata;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_index      (ex_index),
        .ex_data       (ex_data),
        .ex_store_data (ex_store_data),
        .flush         (flush),
        .stall_o       (stall_o),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .MEM_opcode    (MEM_opcode),
        .MEM_index     (MEM_index),
        .MEM_data      (MEM_data),
        .WB_opcode     (WB_opcode),
        .WB_index      (WB_index),
        .WB_data       (WB_data),
        .rf_we         (rf_we),
        .rf_windex     (rf_windex),
        .rf_wdata      (rf_wdata)
`ifdef STALL_COUNT_EN
       ,.stall_cycles  (stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [3:0] op, input logic [3:0] idx,
                            input logic [31:0] d, input logic [31:0] sd);
        ex_valid      = v;
        ex_opcode     = op;
        ex_index      = idx;
        ex_data       = d;
        ex_store_data = sd;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0;
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        #12;
        check("rst_mem_op",  32'(MEM_opcode), 0);
        check("rst_wb_op",   32'(WB_opcode), 0);
        check("rst_stall",   32'(stall_o), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_rf_we",   32'(rf_we), 0);
        check("rst_wb_data", WB_data, 0);
        rst_n = 1'b1;
        tick();

        // 1: ADD r3 <- 5
        drive_ex(1'b1, OP_ADD, 4'd3, 32'd5, 32'd0);
        tick();
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        check("add_mem_op",  32'(MEM_opcode), 32'hC);
        check("add_mem_idx", 32'(MEM_index), 3);
        check("add_mem_dat", MEM_data, 5);
        tick();
        check("add_wb_op",   32'(WB_opcode), 32'hC);
        check("add_rf_we",   32'(rf_we), 1);
        check("add_rf_idx",  32'(rf_windex), 3);
        check("add_rf_dat",  rf_wdata, 5);

        // 2: LW r4 <- [0x10], three cycles without ready
        drive_ex(1'b1, OP_LW, 4'd4, 32'h10, 32'd0);
        mem_ready = 1'b0;
        tick();
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("lw_stall",   32'(stall_o), 1);
            check("lw_req",     32'(mem_req), 1);
            check("lw_we",      32'(mem_we), 0);
            check("lw_addr",    mem_addr, 32'h10);
            tick();
            check("lw_wb_bub",  32'(WB_opcode), 0);
            check("lw_rf_we0",  32'(rf_we), 0);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hAB;
        #1;
        check("lw_unstall",  32'(stall_o), 0);
        tick();
        check("lw_wb_op",    32'(WB_opcode), 4);
        check("lw_wb_idx",   32'(WB_index), 4);
        check("lw_wb_dat",   WB_data, 32'hAB);
        check("lw_rf_we",    32'(rf_we), 1);
        check("lw_mem_nop",  32'(MEM_opcode), 0);
`ifdef STALL_COUNT_EN
        check("lw_stall_cnt", 32'(stall_cycles), 3);
`endif

        // 3: SW [0x20] <- 0x77
        drive_ex(1'b1, OP_SW, 4'd5, 32'h20, 32'h77);
        tick();
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        check("sw_req",      32'(mem_req), 1);
        check("sw_we",       32'(mem_we), 1);
        check("sw_addr",     mem_addr, 32'h20);
        check("sw_wdata",    mem_wdata, 32'h77);
        check("sw_stall",    32'(stall_o), 0);
        tick();
        check("sw_wb_op",    32'(WB_opcode), 3);
        check("sw_rf_we",    32'(rf_we), 0);

        // 4: flushed ADD, then BRANCH
        drive_ex(1'b1, OP_ADD, 4'd6, 32'h99, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        check("fl_mem_op",   32'(MEM_opcode), 0);
        check("fl_mem_dat",  MEM_data, 0);
        tick();
        check("fl_wb_op",    32'(WB_opcode), 0);
        check("fl_rf_we",    32'(rf_we), 0);
        drive_ex(1'b1, OP_BRANCH, 4'd7, 32'd9, 32'd0);
        tick();
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        tick();
        check("br_wb_op",    32'(WB_opcode), 2);
        check("br_rf_we",    32'(rf_we), 0);

        // 5: reset while a load waits
        drive_ex(1'b1, OP_LW, 4'd8, 32'h40, 32'd0);
        mem_ready = 1'b0;
        tick();
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        tick();
        check("rw_stall_pre", 32'(stall_o), 1);
        rst_n = 1'b0;
        #1;
        check("rw_req",      32'(mem_req), 0);
        check("rw_stall",    32'(stall_o), 0);
        check("rw_mem_op",   32'(MEM_opcode), 0);
        check("rw_addr",     mem_addr, 0);
        check("rw_wb_op",    32'(WB_opcode), 0);
        check("rw_rf_we",    32'(rf_we), 0);
`ifdef STALL_COUNT_EN
        check("rw_stall_cnt", 32'(stall_cycles), 0);
`endif
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();

        // 6: back-to-back loads, one wait cycle each
        drive_ex(1'b1, OP_LW, 4'd1, 32'h30, 32'd0);
        mem_ready = 1'b0;
        tick();
        drive_ex(1'b1, OP_LW, 4'd2, 32'h34, 32'd0);
        check("bb_addr1",    mem_addr, 32'h30);
        tick();
        check("bb_bub1",     32'(WB_opcode), 0);
        check("bb_hold1",    mem_addr, 32'h30);
        mem_ready = 1'b1;
        mem_rdata = 32'h111;
        tick();
        drive_ex(1'b0, OP_NOP, 4'd0, 32'd0, 32'd0);
        mem_ready = 1'b0;
        check("bb_wb1_idx",  32'(rf_windex), 1);
        check("bb_wb1_dat",  rf_wdata, 32'h111);
        check("bb_wb1_we",   32'(rf_we), 1);
        check("bb_addr2",    mem_addr, 32'h34);
        tick();
        check("bb_bub2",     32'(WB_opcode), 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h222;
        tick();
        check("bb_wb2_op",   32'(WB_opcode), 4);
        check("bb_wb2_idx",  32'(rf_windex), 2);
        check("bb_wb2_dat",  rf_wdata, 32'h222);
`ifdef STALL_COUNT_EN
        check("bb_stall_cnt", 32'(stall_cycles), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
